window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen_pkg.sv | 25 ++
 rtl/window_3x3_gen_line_buffer.sv | 24 ++
 rtl/window_3x3_gen.sv | 99 +++++++++
 tb/tb_window_3x3_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared constants for the 3x3 sliding-window generator.
package window_3x3_gen_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned WIN_SIZE  = 3;
  localparam int unsigned WIN_TAPS  = WIN_SIZE * WIN_SIZE;
  localparam int unsigned COORD_W   = 16;

  // Window slice indices, k = 3*r + c, r=0 top (oldest) row, c=0 left (oldest) column.
  localparam int unsigned K_TL = 0;
  localparam int unsigned K_TC = 1;
  localparam int unsigned K_TR = 2;
  localparam int unsigned K_ML = 3;
  localparam int unsigned K_MC = 4;
  localparam int unsigned K_MR = 5;
  localparam int unsigned K_BL = 6;
  localparam int unsigned K_BC = 7;
  localparam int unsigned K_BR = 8;

  // Slice index of window tap (r, c).
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * WIN_SIZE + c;
  endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-port row store: combinational read of the old word, write on the clock edge.
module line_buffer #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the word stored before this cycle's write.
  assign dout = mem[addr];

  // Contents are never reset; stale data is hidden by the window gating.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-order 3x3 neighbourhood generator built from two row buffers.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned DATA_W = PIX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_pixel,
  output logic                       out_valid,
  output logic [WIN_TAPS*DATA_W-1:0] out_win,
  output logic [COORD_W-1:0]         out_row,
  output logic [COORD_W-1:0]         out_col,
  output logic                       out_frame_done
);

  localparam int unsigned ADDR_W = $clog2(IMG_W);
  localparam int unsigned WIN_W  = WIN_TAPS * DATA_W;

  logic [COORD_W-1:0] row, col;
  logic [COORD_W-1:0] pos_row, pos_col;
  logic [COORD_W-1:0] nxt_row, nxt_col;
  logic               last_col, last_row, win_ok;
  logic [DATA_W-1:0]  lb1_dout, lb2_dout;
  logic [WIN_W-1:0]   win_sr, win_nxt;

  // lb1 holds row-1, lb2 holds row-2 (fed from lb1's old word).
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .we   (in_valid),
    .addr (ADDR_W'(pos_col)),
    .din  (in_pixel),
    .dout (lb1_dout)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
    .clk  (clk),
    .we   (in_valid),
    .addr (ADDR_W'(pos_col)),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // Position of the pixel on the bus (SOF forces 0,0) and the counters that follow it.
  always_comb begin
    pos_row  = in_sof ? '0 : row;
    pos_col  = in_sof ? '0 : col;
    last_col = (pos_col == COORD_W'(IMG_W - 1));
    last_row = (pos_row == COORD_W'(IMG_H - 1));
    win_ok   = (pos_row >= COORD_W'(WIN_SIZE - 1)) && (pos_col >= COORD_W'(WIN_SIZE - 1));
    nxt_col  = last_col ? '0 : COORD_W'(pos_col + COORD_W'(1));
    nxt_row  = pos_row;
    if (last_col) nxt_row = last_row ? '0 : COORD_W'(pos_row + COORD_W'(1));
  end

  // Window after shifting in the new column {lb2, lb1, in_pixel}.
  always_comb begin
    win_nxt = '0;
    for (int unsigned r = 0; r < WIN_SIZE; r++) begin
      win_nxt[DATA_W*win_idx(r, 0) +: DATA_W] = win_sr[DATA_W*win_idx(r, 1) +: DATA_W];
      win_nxt[DATA_W*win_idx(r, 1) +: DATA_W] = win_sr[DATA_W*win_idx(r, 2) +: DATA_W];
    end
    win_nxt[DATA_W*K_TR +: DATA_W] = lb2_dout;
    win_nxt[DATA_W*K_MR +: DATA_W] = lb1_dout;
    win_nxt[DATA_W*K_BR +: DATA_W] = in_pixel;
  end

  // Counters, shift register and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row            <= '0;
      col            <= '0;
      win_sr         <= '0;
      out_valid      <= 1'b0;
      out_frame_done <= 1'b0;
      out_win        <= '0;
      out_row        <= '0;
      out_col        <= '0;
    end else begin
      out_valid      <= in_valid && win_ok;
      out_frame_done <= in_valid && last_row && last_col;
      if (in_valid) begin
        row    <= nxt_row;
        col    <= nxt_col;
        win_sr <= win_nxt;
        if (win_ok) begin
          out_win <= win_nxt;
          out_row <= COORD_W'(pos_row - COORD_W'(1));
          out_col <= COORD_W'(pos_col - COORD_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized and directed bench for window_3x3_gen against a frame-store model.
module tb_window_3x3_gen;

  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 9 * DW;
  localparam logic [WW-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          out_valid;
  logic [WW-1:0] out_win;
  logic [15:0]   out_row;
  logic [15:0]   out_col;
  logic          out_frame_done;

  window_3x3_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_sof         (in_sof),
    .in_pixel       (in_pixel),
    .out_valid      (out_valid),
    .out_win        (out_win),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_frame_done (out_frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: whole-frame pixel store plus raster position.
  int            img [IMG_H][IMG_W];
  int            m_row, m_col;
  logic [WW-1:0] exp_win;
  int            exp_r, exp_c;
  int            nwin;
  logic [WW-1:0] first_win;
  bit            got_first;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row   = 0;
    m_col   = 0;
    exp_win = '0;
    exp_r   = 0;
    exp_c   = 0;
  endtask

  task automatic step(input bit v, input bit sof, input logic [DW-1:0] px);
    bit ev, efd;
    int pr, pc;
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_pixel = px;
    ev  = 1'b0;
    efd = 1'b0;
    if (v) begin
      pr = sof ? 0 : m_row;
      pc = sof ? 0 : m_col;
      img[pr][pc] = int'(px);
      if (pr >= 2 && pc >= 2) begin
        ev = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[DW*(3*r+c) +: DW] = DW'(img[pr-2+r][pc-2+c]);
        exp_r = pr - 1;
        exp_c = pc - 1;
      end
      efd = (pr == IMG_H - 1) && (pc == IMG_W - 1);
      if (pc == IMG_W - 1) begin
        m_col = 0;
        m_row = (pr == IMG_H - 1) ? 0 : pr + 1;
      end else begin
        m_col = pc + 1;
        m_row = pr;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 128'(out_valid), 128'(ev));
    check("out_frame_done", 128'(out_frame_done), 128'(efd));
    check("out_win", 128'(out_win), 128'(exp_win));
    check("out_row", 128'(out_row), 128'(16'(exp_r)));
    check("out_col", 128'(out_col), 128'(16'(exp_c)));
    if (out_valid) begin
      nwin++;
      if (!got_first) begin
        first_win = out_win;
        got_first = 1'b1;
      end
    end
  endtask

  // Feed n pixels valued 16*row+col, optionally SOF on the first and an idle cycle after each.
  task automatic feed(input int n, input bit sof_first, input bit gaps);
    bit s;
    int pr, pc;
    for (int i = 0; i < n; i++) begin
      s  = sof_first && (i == 0);
      pr = s ? 0 : m_row;
      pc = s ? 0 : m_col;
      step(1'b1, s, DW'(16 * pr + pc));
      if (gaps) step(1'b0, 1'b0, DW'($urandom));
    end
  endtask

  // Hold reset with in_valid toggling; every output must stay at zero.
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_sof   = 1'b0;
      in_pixel = DW'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_win", 128'(out_win), 128'(0));
      check("rst_frame_done", 128'(out_frame_done), 128'(0));
      check("rst_out_row", 128'(out_row), 128'(0));
      check("rst_out_col", 128'(out_col), 128'(0));
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    bit v, s;
    for (int r = 0; r < int'(IMG_H); r++)
      for (int c = 0; c < int'(IMG_W); c++)
        img[r][c] = 0;
    model_reset();

    apply_reset(6);

    // Continuous frame with SOF on the first pixel.
    nwin = 0; got_first = 1'b0;
    feed(16, 1'b1, 1'b0);
    check("cont_nwin", 128'(nwin), 128'(4));
    check("cont_first_win", 128'(first_win), 128'(FIRST_WIN));

    // Same frame with idle cycles between pixels.
    nwin = 0; got_first = 1'b0;
    feed(16, 1'b1, 1'b1);
    check("gap_nwin", 128'(nwin), 128'(4));
    check("gap_first_win", 128'(first_win), 128'(FIRST_WIN));

    // Rows 0-1 of the following frame give no windows.
    nwin = 0;
    feed(8, 1'b0, 1'b0);
    check("next_rows01_nwin", 128'(nwin), 128'(0));

    // SOF arriving at counter position (2,1).
    feed(1, 1'b0, 1'b0);
    nwin = 0; got_first = 1'b0;
    feed(8, 1'b1, 1'b0);
    check("midsof_rows01_nwin", 128'(nwin), 128'(0));
    feed(8, 1'b0, 1'b0);
    check("midsof_nwin", 128'(nwin), 128'(4));
    check("midsof_first_win", 128'(first_win), 128'(FIRST_WIN));

    // Reset pulse after pixel (2,0), then restart without SOF.
    feed(9, 1'b1, 1'b0);
    apply_reset(3);
    nwin = 0; got_first = 1'b0;
    feed(8, 1'b0, 1'b0);
    check("postrst_rows01_nwin", 128'(nwin), 128'(0));
    feed(3, 1'b0, 1'b0);
    check("postrst_nwin", 128'(nwin), 128'(1));
    check("postrst_first_win", 128'(first_win), 128'(FIRST_WIN));
    check("postrst_centre_row", 128'(out_row), 128'(1));
    check("postrst_centre_col", 128'(out_col), 128'(1));

    // Random valid gaps, pixel values and occasional SOF.
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 40) == 0);
      step(v, s, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
